// File: rtl/scope_report_sched.sv
// scope_report_sched
// Phased round-robin scheduler. NREQ reporters share one message channel
// through a single registered output slot with a valid/ready handshake.
// A cycle counter opens reporter i's phase at cycle PHASE_BASE+i. When the
// counter reaches FINISH_CYC, no new grants are made. The slot is drained,
// and then a sticky done is raised until the next reset.
module scope_report_sched #(
    parameter int NREQ       = 4,
    parameter int DW         = 32,
    parameter int PHASE_BASE = 2,
    parameter int FINISH_CYC = 8,
    parameter int CW         = 8,
    localparam int SW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               out_valid,
    output logic [DW-1:0]      out_data,
    output logic [SW-1:0]      out_src,
    input  logic               out_ready,
    output logic [CW-1:0]      cyc,
    output logic [NREQ-1:0]    phase_en,
    output logic [15:0]        out_count,
    output logic               done
);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [SW-1:0]   rr_ptr;
    logic [NREQ-1:0] elig;
    logic            load_ok;
    logic            grant_hit;
    logic [SW-1:0]   grant_idx;
    logic [SW-1:0]   scan_idx [NREQ];

    // A reporter's phase opens at PHASE_BASE+i and stays open for the rest of RUN.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        phase_en = '0;
        for (int i = 0; i < NREQ; i++) begin
            phase_en[i] = (state == S_RUN) && (int'(cyc) >= PHASE_BASE + i);
        end
    end

    assign elig    = req_valid & phase_en;
    assign load_ok = !out_valid || out_ready;
    assign done    = (state == S_DONE);

    // Scan order starts at rr_ptr and wraps around. The first eligible reporter wins.
    always_comb begin
        grant_hit = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx[k] = SW'((int'(rr_ptr) + k) % NREQ);
        end
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_hit && elig[scan_idx[k]]) begin
                grant_hit = 1'b1;
                grant_idx = scan_idx[k];
            end
        end
    end

    // A one-hot ready is raised only when the output slot can take the message this edge.
    always_comb begin
        req_ready = '0;
        if (load_ok && grant_hit) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // RUN stops when the counter reaches FINISH_CYC. DRAIN ends when the slot empties or is accepted.
    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN:   if (int'(cyc) + 1 >= FINISH_CYC) state_nxt = S_DRAIN;
            S_DRAIN: if (!out_valid || out_ready) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_DONE;
            default: state_nxt = S_RUN;
        endcase
    end

    // Update the state register and the cycle counter. The counter saturates at FINISH_CYC and freezes in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_RUN;
            cyc   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so all registers update together at the edge.
            state <= state_nxt;
            if (state != S_DONE && cyc != CW'(FINISH_CYC)) begin
                cyc <= cyc + CW'(1);
            end
        end
    end

    // Output slot: load the granted message, or empty the slot when it was consumed and nothing is eligible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            rr_ptr    <= '0;
        end else if (load_ok) begin
            if (grant_hit) begin
                out_valid <= 1'b1;
                out_data  <= req_data[int'(grant_idx)*DW +: DW];
                out_src   <= grant_idx;
                rr_ptr    <= (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + SW'(1);
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    // Count downstream acceptances. The count saturates at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_count <= '0;
        end else if (out_valid && out_ready && out_count != 16'hFFFF) begin
            out_count <= out_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_scope_report_sched.sv
// Directed bench for scope_report_sched (NREQ=4, PHASE_BASE=2, FINISH_CYC=8).
// Inputs are driven on the falling edge, and outputs are sampled 1 ns later.
module tb_scope_report_sched;

    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int SW   = 2;
    localparam int CW   = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               out_valid;
    logic [DW-1:0]      out_data;
    logic [SW-1:0]      out_src;
    logic               out_ready = 1'b0;
    logic [CW-1:0]      cyc;
    logic [NREQ-1:0]    phase_en;
    logic [15:0]        out_count;
    logic               done;

    int n_checks = 0;
    int n_errors = 0;

    // Expected values for the free-flowing sequence, indexed by the cycle count at sampling.
    logic [3:0]  t_pe   [11] = '{4'h0, 4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0};
    logic [3:0]  t_rdy  [11] = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h0, 4'h0, 4'h0};
    logic        t_ov   [11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [1:0]  t_src  [11] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd1, 2'd1};
    logic [15:0] t_cnt  [11] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd6};
    logic        t_done [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    scope_report_sched #(
        .NREQ(NREQ), .DW(DW), .PHASE_BASE(2), .FINISH_CYC(8), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .out_ready(out_ready), .cyc(cyc), .phase_en(phase_en),
        .out_count(out_count), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] msg(input int src);
        return 32'hC0DE_0000 + DW'(src);
    endfunction

    // Assert reset for a full cycle. The task returns on a falling edge with cyc == 0.
    task automatic apply_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // All reporters active, downstream always ready; checked against the tables above.
    task automatic run_full_seq(input string pfx);
        for (int c = 0; c < 11; c++) begin
            req_valid = 4'hF;
            out_ready = 1'b1;
            #1;
            check($sformatf("%s cyc c=%0d", pfx, c), 64'(cyc), 64'((c > 8) ? 8 : c));
            check($sformatf("%s phase_en c=%0d", pfx, c), 64'(phase_en), 64'(t_pe[c]));
            check($sformatf("%s req_ready c=%0d", pfx, c), 64'(req_ready), 64'(t_rdy[c]));
            check($sformatf("%s out_valid c=%0d", pfx, c), 64'(out_valid), 64'(t_ov[c]));
            check($sformatf("%s out_count c=%0d", pfx, c), 64'(out_count), 64'(t_cnt[c]));
            check($sformatf("%s done c=%0d", pfx, c), 64'(done), 64'(t_done[c]));
            if (t_ov[c]) begin
                check($sformatf("%s out_src c=%0d", pfx, c), 64'(out_src), 64'(t_src[c]));
                check($sformatf("%s out_data c=%0d", pfx, c), 64'(out_data), 64'(msg(int'(t_src[c]))));
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int grants [NREQ];
        int accepts [NREQ];

        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = msg(i);

        // ---- Test 1: asynchronous reset mid-stream ----
        apply_reset();
        for (int c = 0; c < 5; c++) begin
            req_valid = 4'hF;
            out_ready = 1'b1;
            @(negedge clk);
        end
        #1;
        check("t1 pre-reset out_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("t1 rst out_valid", 64'(out_valid), 64'd0);
        check("t1 rst cyc", 64'(cyc), 64'd0);
        check("t1 rst out_count", 64'(out_count), 64'd0);
        check("t1 rst out_src", 64'(out_src), 64'd0);
        check("t1 rst out_data", 64'(out_data), 64'd0);
        check("t1 rst req_ready", 64'(req_ready), 64'd0);
        check("t1 rst done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t1 cyc after release", 64'(cyc), 64'd0);
        @(negedge clk);
        #1;
        check("t1 cyc one edge later", 64'(cyc), 64'd1);

        // ---- Test 2: phasing and round-robin ----
        apply_reset();
        run_full_seq("t2");

        // ---- Test 3: sparse, only reporter 3 ----
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            req_valid = 4'b1000;
            out_ready = 1'b1;
            #1;
            if (c < 5) check($sformatf("t3 req_ready c=%0d", c), 64'(req_ready), 64'd0);
            if (c == 5) check("t3 first grant", 64'(req_ready), 64'h8);
            if (c < 6) check($sformatf("t3 out_valid c=%0d", c), 64'(out_valid), 64'd0);
            if (c == 6) begin
                check("t3 first out_valid", 64'(out_valid), 64'd1);
                check("t3 first out_src", 64'(out_src), 64'd3);
                check("t3 first out_data", 64'(out_data), 64'(msg(3)));
            end
            @(negedge clk);
        end

        // ---- Test 4: backpressure for cyc 3..5 ----
        apply_reset();
        for (int i = 0; i < NREQ; i++) begin
            grants[i]  = 0;
            accepts[i] = 0;
        end
        for (int c = 0; c < 11; c++) begin
            req_valid = 4'hF;
            out_ready = !(c >= 3 && c <= 5);
            #1;
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) grants[i]++;
            if (out_valid && out_ready) accepts[out_src]++;
            if (c >= 3 && c <= 5) begin
                check($sformatf("t4 stall req_ready c=%0d", c), 64'(req_ready), 64'd0);
                check($sformatf("t4 stall out_valid c=%0d", c), 64'(out_valid), 64'd1);
                check($sformatf("t4 stall out_src c=%0d", c), 64'(out_src), 64'd0);
                check($sformatf("t4 stall out_data c=%0d", c), 64'(out_data), 64'(msg(0)));
            end
            if (c == 6) check("t4 release grant", 64'(req_ready), 64'h2);
            @(negedge clk);
        end
        check("t4 grants src0", 64'(grants[0]), 64'd1);
        check("t4 grants src1", 64'(grants[1]), 64'd1);
        check("t4 grants src2", 64'(grants[2]), 64'd1);
        check("t4 grants src3", 64'(grants[3]), 64'd0);
        check("t4 accepts src0", 64'(accepts[0]), 64'd1);
        check("t4 accepts src1", 64'(accepts[1]), 64'd1);
        check("t4 accepts src2", 64'(accepts[2]), 64'd1);
        check("t4 accepts src3", 64'(accepts[3]), 64'd0);
        #1;
        check("t4 final out_count", 64'(out_count), 64'd3);
        check("t4 final done", 64'(done), 64'd1);

        // ---- Test 5: drain held off by out_ready = 0 ----
        apply_reset();
        for (int c = 0; c < 12; c++) begin
            req_valid = 4'hF;
            out_ready = !(c == 8 || c == 9);
            #1;
            if (c >= 8 && c <= 10) begin
                check($sformatf("t5 drain phase_en c=%0d", c), 64'(phase_en), 64'd0);
                check($sformatf("t5 drain done c=%0d", c), 64'(done), 64'd0);
                check($sformatf("t5 drain out_valid c=%0d", c), 64'(out_valid), 64'd1);
                check($sformatf("t5 drain out_src c=%0d", c), 64'(out_src), 64'd1);
                check($sformatf("t5 drain req_ready c=%0d", c), 64'(req_ready), 64'd0);
            end
            if (c == 11) begin
                check("t5 done after accept", 64'(done), 64'd1);
                check("t5 out_count", 64'(out_count), 64'd6);
                check("t5 cyc frozen", 64'(cyc), 64'd8);
            end
            @(negedge clk);
        end

        // ---- Test 6: reset from DONE, then repeat the full sequence ----
        #1;
        rst = 1'b1;
        #1;
        check("t6 rst done", 64'(done), 64'd0);
        check("t6 rst cyc", 64'(cyc), 64'd0);
        check("t6 rst out_count", 64'(out_count), 64'd0);
        apply_reset();
        run_full_seq("t6");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
